// File: rtl/kolache_logic_seq.sv
// kolache_logic_seq: multi-cycle bitwise logic unit for the Kolache ALU.
// Operands are captured once, then processed SLICE bits per cycle through one
// narrow slice datapath; the result is held in DONE until the consumer takes it.
// Optional feature macro: KOLACHE_LOGIC_PARITY_EN adds a registered even-parity
// output of the result.
`timescale 1ns/1ps

// One SLICE-wide lane of the logic operation.
module kolache_logic_slice #(
  parameter int W = 8
) (
  input  logic [W-1:0] a_i,
  input  logic [W-1:0] b_i,
  input  logic [2:0]   op_i,
  output logic [W-1:0] y_o
);
  // Per-bit op decode; all eight codes are legal, 111 passes a through.
  always_comb begin
    case (op_i)
      3'b000:  y_o = a_i & b_i;
      3'b001:  y_o = a_i | b_i;
      3'b010:  y_o = a_i ^ b_i;
      3'b011:  y_o = ~(a_i & b_i);
      3'b100:  y_o = ~(a_i | b_i);
      3'b101:  y_o = ~(a_i ^ b_i);
      3'b110:  y_o = a_i & ~b_i;
      default: y_o = a_i;
    endcase
  end
endmodule

module kolache_logic_seq #(
  parameter int WIDTH = 32,
  parameter int SLICE = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [2:0]       op,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] y,
  output logic             zero
`ifdef KOLACHE_LOGIC_PARITY_EN
  ,output logic            parity
`endif
);
  generate
    if (SLICE < 1 || SLICE > WIDTH || (WIDTH % SLICE) != 0) begin : g_bad_cfg
      $error("kolache_logic_seq: SLICE must divide WIDTH and lie in 1..WIDTH");
    end
  endgenerate

  localparam int N  = WIDTH / SLICE;
  localparam int CW = (N > 1) ? $clog2(N) : 1;

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_RUN  = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  logic [1:0]             state_q, state_d;
  logic [CW-1:0]          cnt_q, cnt_d;
  logic [2:0]             op_q;
  // Operands and result viewed as N slices so the counter indexes them directly.
  logic [N-1:0][SLICE-1:0] a_q, b_q, y_q, y_d;
  logic                   zero_q, zero_d;
  logic [SLICE-1:0]       res;
  logic                   last;
  logic                   accept;

  assign accept = (state_q == S_IDLE) && in_valid;
  assign last   = (cnt_q == CW'(N - 1));

  kolache_logic_slice #(.W(SLICE)) u_slice (
    .a_i  (a_q[cnt_q]),
    .b_i  (b_q[cnt_q]),
    .op_i (op_q),
    .y_o  (res)
  );

  // Handshake outputs come straight from the state register.
  assign in_ready  = (state_q == S_IDLE);
  assign out_valid = (state_q == S_DONE);
  assign y         = y_q;
  assign zero      = zero_q;

`ifdef KOLACHE_LOGIC_PARITY_EN
  logic par_q, par_d;
  assign parity = par_q;
`endif

  // Next-state: sequence slices in RUN, latch flags from the completed word.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    y_d     = y_q;
    zero_d  = zero_q;
`ifdef KOLACHE_LOGIC_PARITY_EN
    par_d   = par_q;
`endif
    case (state_q)
      S_IDLE: begin
        if (in_valid) begin
          state_d = S_RUN;
          cnt_d   = '0;
        end
      end
      S_RUN: begin
        y_d[cnt_q] = res;
        cnt_d      = cnt_q + 1'b1;
        if (last) begin
          state_d = S_DONE;
          // Flags see the word including the slice written on this edge.
          zero_d  = (y_d == '0);
`ifdef KOLACHE_LOGIC_PARITY_EN
          par_d   = ^y_d;
`endif
        end
      end
      S_DONE: begin
        if (out_ready) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Control and result registers; reset aborts any operation in flight.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      y_q     <= '0;
      zero_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      y_q     <= y_d;
      zero_q  <= zero_d;
    end
  end

  // Operand capture only on the accept edge; later input changes are ignored.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_q  <= '0;
      b_q  <= '0;
      op_q <= 3'b000;
    end else if (accept) begin
      a_q  <= a;
      b_q  <= b;
      op_q <= op;
    end
  end

`ifdef KOLACHE_LOGIC_PARITY_EN
  // Parity register, updated alongside the zero flag.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) par_q <= 1'b0;
    else        par_q <= par_d;
  end
`endif

endmodule

// File: tb/tb_kolache_logic_seq.sv
// Directed testbench for kolache_logic_seq: default 32/8 instance plus
// 32/32, 8/1 and 8/8 instances for latency and result checks.
`timescale 1ns/1ps

module tb_kolache_logic_seq;
  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        in_valid = 1'b0, out_ready = 1'b0;
  logic [31:0] a = '0, b = '0;
  logic [2:0]  op = '0;
  logic        in_ready, out_valid, zero;
  logic [31:0] y;
`ifdef KOLACHE_LOGIC_PARITY_EN
  logic        parity;
`endif

  // extra parameter instances share operands / handshake controls
  logic        iv_x = 1'b0, or_x = 1'b0;
  logic [31:0] a_x = '0, b_x = '0;
  logic [2:0]  op1 = '0, op2 = '0, op3 = '0;
  logic        ir1, ov1, z1, ir2, ov2, z2, ir3, ov3, z3;
  logic [31:0] y1;
  logic [7:0]  y2, y3;
`ifdef KOLACHE_LOGIC_PARITY_EN
  logic        p1, p2, p3;
`endif

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  kolache_logic_seq #(.WIDTH(32), .SLICE(8)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .a(a), .b(b), .op(op), .out_valid(out_valid), .out_ready(out_ready),
    .y(y), .zero(zero)
`ifdef KOLACHE_LOGIC_PARITY_EN
    , .parity(parity)
`endif
  );

  kolache_logic_seq #(.WIDTH(32), .SLICE(32)) dut_w32s32 (
    .clk(clk), .rst_n(rst_n), .in_valid(iv_x), .in_ready(ir1),
    .a(a_x), .b(b_x), .op(op1), .out_valid(ov1), .out_ready(or_x),
    .y(y1), .zero(z1)
`ifdef KOLACHE_LOGIC_PARITY_EN
    , .parity(p1)
`endif
  );

  kolache_logic_seq #(.WIDTH(8), .SLICE(1)) dut_w8s1 (
    .clk(clk), .rst_n(rst_n), .in_valid(iv_x), .in_ready(ir2),
    .a(a_x[7:0]), .b(b_x[7:0]), .op(op2), .out_valid(ov2), .out_ready(or_x),
    .y(y2), .zero(z2)
`ifdef KOLACHE_LOGIC_PARITY_EN
    , .parity(p2)
`endif
  );

  kolache_logic_seq #(.WIDTH(8), .SLICE(8)) dut_w8s8 (
    .clk(clk), .rst_n(rst_n), .in_valid(iv_x), .in_ready(ir3),
    .a(a_x[7:0]), .b(b_x[7:0]), .op(op3), .out_valid(ov3), .out_ready(or_x),
    .y(y3), .zero(z3)
`ifdef KOLACHE_LOGIC_PARITY_EN
    , .parity(p3)
`endif
  );

  // Issue one op on the main instance; lat = edges from accept to out_valid
  // (99 if it never arrives). Leaves the unit sitting in DONE.
  task automatic run_op(input logic [31:0] ai, input logic [31:0] bi,
                        input logic [2:0] oi, output int lat);
    @(negedge clk);
    a = ai; b = bi; op = oi; in_valid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    lat = 0;
    while (!out_valid && lat < 99) begin
      @(posedge clk); lat++; @(negedge clk);
    end
  endtask

  // Take the result: one edge with out_ready high.
  task automatic take_result();
    @(negedge clk); out_ready = 1'b1;
    @(posedge clk);
    @(negedge clk); out_ready = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    n_cmp++; if (in_ready !== 1'b1) begin n_err++; $display("FAIL reset_in_ready got %b want 1", in_ready); end
    n_cmp++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL reset_out_valid got %b want 0", out_valid); end
    n_cmp++; if (y !== 32'h0) begin n_err++; $display("FAIL reset_y got %h want 00000000", y); end
    n_cmp++; if (zero !== 1'b0) begin n_err++; $display("FAIL reset_zero got %b want 0", zero); end
`ifdef KOLACHE_LOGIC_PARITY_EN
    n_cmp++; if (parity !== 1'b0) begin n_err++; $display("FAIL reset_parity got %b want 0", parity); end
`endif
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_first_op();
    int lat;
    run_op(32'hFFFFFFFF, 32'h0000003B, 3'b000, lat);
    n_cmp++; if (lat != 4) begin n_err++; $display("FAIL first_latency got %0d want 4", lat); end
    n_cmp++; if (y !== 32'h0000003B) begin n_err++; $display("FAIL first_y got %h want 0000003b", y); end
    n_cmp++; if (zero !== 1'b0) begin n_err++; $display("FAIL first_zero got %b want 0", zero); end
    take_result();
    n_cmp++; if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
      n_err++; $display("FAIL first_handshake got ov=%b ir=%b want ov=0 ir=1", out_valid, in_ready); end
  endtask

  task automatic test_and_nor();
    int lat;
    run_op(32'h00000072, 32'h0000005B, 3'b000, lat);
    n_cmp++; if (y !== 32'h00000052) begin n_err++; $display("FAIL and_y got %h want 00000052", y); end
    n_cmp++; if (zero !== 1'b0) begin n_err++; $display("FAIL and_zero got %b want 0", zero); end
    take_result();
    run_op(32'hFFFFFFFF, 32'h00000000, 3'b100, lat);
    n_cmp++; if (y !== 32'h00000000) begin n_err++; $display("FAIL nor_y got %h want 00000000", y); end
    n_cmp++; if (zero !== 1'b1) begin n_err++; $display("FAIL nor_zero got %b want 1", zero); end
    n_cmp++; if (lat != 4) begin n_err++; $display("FAIL nor_latency got %0d want 4", lat); end
    take_result();
  endtask

  task automatic test_op_sweep();
    logic [31:0] exp_y [8];
    int lat;
    exp_y[0] = 32'hF0008421; exp_y[1] = 32'hFFF0EDB7;
    exp_y[2] = 32'h0FF06996; exp_y[3] = 32'h0FFF7BDE;
    exp_y[4] = 32'h000F1248; exp_y[5] = 32'hF00F9669;
    exp_y[6] = 32'h00F02184; exp_y[7] = 32'hF0F0A5A5;
    for (int k = 0; k < 8; k++) begin
      run_op(32'hF0F0A5A5, 32'hFF00CC33, 3'(k), lat);
      n_cmp++; if (y !== exp_y[k]) begin n_err++; $display("FAIL sweep_op%0d_y got %h want %h", k, y, exp_y[k]); end
      n_cmp++; if (lat != 4) begin n_err++; $display("FAIL sweep_op%0d_latency got %0d want 4", k, lat); end
      take_result();
    end
  endtask

  task automatic test_back_pressure();
    int lat;
    int bad_y, bad_ir, bad_ov;
    run_op(32'h12345678, 32'h0F0F0F0F, 3'b010, lat);
    bad_y = 0; bad_ir = 0; bad_ov = 0;
    for (int c = 0; c < 10; c++) begin
      a = $urandom; b = $urandom; in_valid = ~in_valid; op = 3'(c);
      @(posedge clk); @(negedge clk);
      if (y !== 32'h1D3B5977) bad_y++;
      if (in_ready !== 1'b0) bad_ir++;
      if (out_valid !== 1'b1) bad_ov++;
    end
    in_valid = 1'b0;
    n_cmp++; if (bad_y != 0) begin n_err++; $display("FAIL bp_y_hold got %h (%0d bad cycles) want 1d3b5977", y, bad_y); end
    n_cmp++; if (bad_ir != 0) begin n_err++; $display("FAIL bp_in_ready got %0d cycles high want 0", bad_ir); end
    n_cmp++; if (bad_ov != 0) begin n_err++; $display("FAIL bp_out_valid got %0d cycles low want 0", bad_ov); end
    // complete transfer, then issue on the very next edge
    out_ready = 1'b1;
    @(posedge clk); @(negedge clk);
    out_ready = 1'b0;
    n_cmp++; if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
      n_err++; $display("FAIL bp_release got ir=%b ov=%b want ir=1 ov=0", in_ready, out_valid); end
    a = 32'h0000FFFF; b = 32'h00FF00FF; op = 3'b001; in_valid = 1'b1;
    @(posedge clk); @(negedge clk);
    in_valid = 1'b0;
    n_cmp++; if (in_ready !== 1'b0) begin n_err++; $display("FAIL bp_next_accept got ir=%b want 0", in_ready); end
    lat = 0;
    while (!out_valid && lat < 99) begin @(posedge clk); lat++; @(negedge clk); end
    n_cmp++; if (lat != 4 || y !== 32'h00FFFFFF) begin
      n_err++; $display("FAIL bp_next_result got lat=%0d y=%h want lat=4 y=00ffffff", lat, y); end
    take_result();
  endtask

  task automatic test_reset_abort();
    int seen, lat;
    @(negedge clk);
    a = 32'hAAAAAAAA; b = 32'h55555555; op = 3'b001; in_valid = 1'b1;
    @(posedge clk); @(negedge clk);
    in_valid = 1'b0;
    @(posedge clk); @(posedge clk); @(negedge clk);   // two RUN edges done
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    seen = 0;
    n_cmp++; if (in_ready !== 1'b1) begin n_err++; $display("FAIL abort_in_ready got %b want 1", in_ready); end
    for (int c = 0; c < 10; c++) begin
      @(posedge clk); @(negedge clk);
      if (out_valid === 1'b1) seen++;
    end
    n_cmp++; if (seen != 0) begin n_err++; $display("FAIL abort_out_valid got %0d cycles high want 0", seen); end
    run_op(32'h0000FF00, 32'h00000F0F, 3'b110, lat);
    n_cmp++; if (lat != 4 || y !== 32'h0000F000) begin
      n_err++; $display("FAIL abort_fresh got lat=%0d y=%h want lat=4 y=0000f000", lat, y); end
    take_result();
  endtask

  task automatic test_params();
    int lat1, lat2, lat3;
    lat1 = 99; lat2 = 99; lat3 = 99;
    @(negedge clk);
    a_x = 32'hF0F0A5A5; b_x = 32'hFF00CC33;
    op1 = 3'b010; op2 = 3'b001; op3 = 3'b110;
    iv_x = 1'b1;
    @(posedge clk); @(negedge clk);
    iv_x = 1'b0;
    for (int c = 1; c <= 12; c++) begin
      @(posedge clk); @(negedge clk);
      if (ov1 && lat1 == 99) lat1 = c;
      if (ov2 && lat2 == 99) lat2 = c;
      if (ov3 && lat3 == 99) lat3 = c;
    end
    n_cmp++; if (lat1 != 1) begin n_err++; $display("FAIL p32s32_latency got %0d want 1", lat1); end
    n_cmp++; if (y1 !== 32'h0FF06996) begin n_err++; $display("FAIL p32s32_y got %h want 0ff06996", y1); end
    n_cmp++; if (lat2 != 8) begin n_err++; $display("FAIL p8s1_latency got %0d want 8", lat2); end
    n_cmp++; if (y2 !== 8'hB7) begin n_err++; $display("FAIL p8s1_y got %h want b7", y2); end
    n_cmp++; if (lat3 != 1) begin n_err++; $display("FAIL p8s8_latency got %0d want 1", lat3); end
    n_cmp++; if (y3 !== 8'h84 || z3 !== 1'b0) begin n_err++; $display("FAIL p8s8_y got %h z=%b want 84 z=0", y3, z3); end
    or_x = 1'b1;
    @(posedge clk); @(negedge clk);
    or_x = 1'b0;
    n_cmp++; if (ir1 !== 1'b1 || ir2 !== 1'b1 || ir3 !== 1'b1) begin
      n_err++; $display("FAIL params_release got ir=%b%b%b want 111", ir1, ir2, ir3); end
  endtask

`ifdef KOLACHE_LOGIC_PARITY_EN
  task automatic test_parity();
    int lat;
    run_op(32'h00000007, 32'h0, 3'b111, lat);
    n_cmp++; if (parity !== 1'b1) begin n_err++; $display("FAIL parity_7 got %b want 1", parity); end
    take_result();
    run_op(32'h00000003, 32'h0, 3'b111, lat);
    n_cmp++; if (parity !== 1'b0) begin n_err++; $display("FAIL parity_3 got %b want 0", parity); end
    take_result();
  endtask
`endif

  initial begin
    test_reset();
    test_first_op();
    test_and_nor();
    test_op_sweep();
    test_back_pressure();
    test_reset_abort();
    test_params();
`ifdef KOLACHE_LOGIC_PARITY_EN
    test_parity();
`endif
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
